// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and default width shared by the sequential ALU
package alu_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MUL  = 3'b100,
        OP_SLTU = 3'b101,
        OP_DIVU = 3'b110,
        OP_REMU = 3'b111
    } op_e;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between an ALU client and alu_seq
interface alu_seq_if #(parameter int WIDTH = alu_pkg::DEFAULT_WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    modport master (output in_valid, SrcA, SrcB, ALUControl, out_ready,
                    input in_ready, out_valid, ALUResult, Zero);
    modport slave (input in_valid, SrcA, SrcB, ALUControl, out_ready,
                   output in_ready, out_valid, ALUResult, Zero);
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider sharing registers
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] prod,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    // acc: partial product / partial remainder; x: multiplicand / dividend-quotient; y: multiplier / divisor
    logic [WIDTH-1:0] acc, x, y;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   t;
    logic             ge;
    always_comb begin
        t    = {acc, x[WIDTH-1]};
        ge   = t >= {1'b0, y};
        prod = acc + (y[0] ? x : '0);
        quo  = {x[WIDTH-2:0], ge};
        rem  = ge ? WIDTH'(t - {1'b0, y}) : t[WIDTH-1:0];
        last = cnt == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            x   <= '0;
            y   <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            x   <= a;
            y   <= b;
            cnt <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            acc <= div ? rem : prod;
            x   <= div ? quo : x << 1;
            y   <= div ? y : y >> 1;
            cnt <= last ? cnt : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith ops and iterative MUL/DIVU/REMU
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    state_e           state, state_n;
    op_e              op, op_q;
    logic [WIDTH-1:0] a, b, single, res_n, result, prod, quo, rem;
    logic             accept, ld, last, zero;
    assign op = op_e'(bus.ALUControl);
    assign a  = bus.SrcA;
    assign b  = bus.SrcB;
    always_comb begin
        single = op == OP_ADD ? a + b :
                 op == OP_SUB ? a - b :
                 op == OP_AND ? a & b :
                 op == OP_OR  ? a | b : WIDTH'(a < b);
        accept  = state == IDLE && bus.in_valid;
        state_n = state;
        ld      = 1'b0;
        res_n   = single;
        case (state)
            IDLE: if (accept) begin
                state_n = op == OP_MUL ? MUL : (op == OP_DIVU || op == OP_REMU) ? DIV : DONE;
                ld      = state_n == DONE;
            end
            MUL: if (last) begin
                state_n = DONE;
                ld      = 1'b1;
                res_n   = prod;
            end
            DIV: if (last) begin
                state_n = DONE;
                ld      = 1'b1;
                res_n   = op_q == OP_REMU ? rem : quo;
            end
            DONE: state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            state <= state_n;
            if (accept) op_q <= op;
            if (ld) begin
                result <= res_n;
                zero   <= res_n == '0;
            end
        end
    end
    alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (state == MUL || state == DIV),
        .div  (state == DIV),
        .a    (a),
        .b    (b),
        .last (last),
        .prod (prod),
        .quo  (quo),
        .rem  (rem)
    );
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.ALUResult = result;
    assign bus.Zero      = zero;
endmodule
